inta_sequencer: RTL and testbench

// - CPU-side responder to the 8259A PIC INT output; sits between the PIC and the CPU core.
// - When INT is pending, IF=1 and the core signals an instruction boundary, it drives the two-pulse INTA_n cycle.
// - It captures the 8-bit vector the PIC places on the data bus during the second INTA pulse.
// - It hands that vector to the core over a valid/ready handshake.

---
 rtl/inta_sequencer.sv | 152 +++++++++++++++
 tb/tb_inta_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// Responds to the 8259A INT line with the two-pulse INTA_n cycle, captures the vector on pulse 2
// and hands it to the core over valid/ready. Optional macro: INTA_SPURIOUS_DROP_EN.
module inta_sequencer #(
    parameter int INTA_LOW_CYCLES = 4,
    parameter int INTA_GAP_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       int_req,
    input  logic       if_flag,
    input  logic       instr_boundary,
    input  logic [7:0] data_bus,
    output logic       inta_n,
    output logic [7:0] vec,
    output logic       vec_valid,
    input  logic       vec_ready,
    output logic       ack_busy,
    output logic [7:0] spurious_cnt
);

    localparam int LOW_EFF = (INTA_LOW_CYCLES < 1) ? 1 : INTA_LOW_CYCLES;
    localparam int GAP_EFF = (INTA_GAP_CYCLES < 1) ? 1 : INTA_GAP_CYCLES;
    localparam int MAX_EFF = (LOW_EFF > GAP_EFF) ? LOW_EFF : GAP_EFF;
    localparam int CW      = $clog2(MAX_EFF + 1);
    localparam logic [CW-1:0] LOW_LD = CW'(LOW_EFF);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_EFF);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INTA1   = 3'd1,
        GAP     = 3'd2,
        INTA2   = 3'd3,
        DELIVER = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, int_s;
    logic          inta_n_q;
    logic [7:0]    vec_q, vec_d;
    logic          vec_valid_q;
    logic          ack_busy_q;

`ifdef INTA_SPURIOUS_DROP_EN
    logic       spur_q, spur_d;
    logic [7:0] spur_cnt_q, spur_cnt_d;
`endif

    // Handshake: a vector transfers on any edge where vec_valid and vec_ready are both high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
`ifdef INTA_SPURIOUS_DROP_EN
        spur_d     = spur_q;
        spur_cnt_d = spur_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (int_s && if_flag && instr_boundary) begin
                    state_d = INTA1;
                    cnt_d   = LOW_LD;
                end
            end
            INTA1: begin
                if (cnt_q == CW'(1)) begin
                    state_d = GAP;
                    cnt_d   = GAP_LD;
`ifdef INTA_SPURIOUS_DROP_EN
                    spur_d  = ~int_s;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CW'(1)) begin
                    state_d = INTA2;
                    cnt_d   = LOW_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            INTA2: begin
                if (cnt_q == CW'(1)) begin
`ifdef INTA_SPURIOUS_DROP_EN
                    if (spur_q) begin
                        state_d = IDLE;
                        if (spur_cnt_q != 8'hFF) spur_cnt_d = spur_cnt_q + 8'd1;
                    end else begin
                        state_d = DELIVER;
                        vec_d   = data_bus;
                    end
`else
                    state_d = DELIVER;
                    vec_d   = data_bus;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DELIVER: begin
                if (vec_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            int_s       <= 1'b0;
            inta_n_q    <= 1'b1;
            vec_q       <= 8'd0;
            vec_valid_q <= 1'b0;
            ack_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= int_req;
            int_s       <= sync1_q;
            inta_n_q    <= !((state_d == INTA1) || (state_d == INTA2));
            vec_q       <= vec_d;
            vec_valid_q <= (state_d == DELIVER);
            ack_busy_q  <= (state_d != IDLE);
        end
    end

`ifdef INTA_SPURIOUS_DROP_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spur_q     <= 1'b0;
            spur_cnt_q <= 8'd0;
        end else begin
            spur_q     <= spur_d;
            spur_cnt_q <= spur_cnt_d;
        end
    end
    assign spurious_cnt = spur_cnt_q;
`else
    assign spurious_cnt = 8'd0;
`endif

    assign inta_n    = inta_n_q;
    assign vec       = vec_q;
    assign vec_valid = vec_valid_q;
    assign ack_busy  = ack_busy_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: default-parameter instance plus a LOW=1/GAP=0 instance.
module tb_inta_sequencer;

    logic       clk;
    logic       reset_n;
    logic       int_req, if_flag, instr_boundary, vec_ready;
    logic [7:0] data_bus;
    logic       inta_n, vec_valid, ack_busy;
    logic [7:0] vec, spurious_cnt;

    logic       int_req2, strobe2, vec_ready2;
    logic [7:0] data_bus2;
    logic       inta_n2, vec_valid2, ack_busy2;
    logic [7:0] vec2, spurious_cnt2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    inta_sequencer dut (
        .clk(clk), .reset_n(reset_n), .int_req(int_req), .if_flag(if_flag),
        .instr_boundary(instr_boundary), .data_bus(data_bus), .inta_n(inta_n),
        .vec(vec), .vec_valid(vec_valid), .vec_ready(vec_ready), .ack_busy(ack_busy),
        .spurious_cnt(spurious_cnt)
    );

    inta_sequencer #(.INTA_LOW_CYCLES(1), .INTA_GAP_CYCLES(0)) dut_fast (
        .clk(clk), .reset_n(reset_n), .int_req(int_req2), .if_flag(if_flag),
        .instr_boundary(strobe2), .data_bus(data_bus2), .inta_n(inta_n2),
        .vec(vec2), .vec_valid(vec_valid2), .vec_ready(vec_ready2), .ack_busy(ack_busy2),
        .spurious_cnt(spurious_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts at the first low cycle of pulse 1; ends at the first sample after pulse 2.
    task automatic measure_pulses(output int l1, output int g, output int l2);
        bit done;
        l1 = 1; g = 1; l2 = 1;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (inta_n == 1'b0) l1++; else done = 1;
        end
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (inta_n == 1'b1) g++; else done = 1;
        end
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (inta_n == 1'b0) l2++; else done = 1;
        end
    endtask

    // Assumes int_s is already high; strobes once and leaves the DUT in its first low cycle.
    task automatic strobe_start();
        instr_boundary = 1'b1;
        step();
        instr_boundary = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; int_req = 1'b0; if_flag = 1'b0; instr_boundary = 1'b0;
        vec_ready = 1'b0; data_bus = 8'h00;
        int_req2 = 1'b0; strobe2 = 1'b0; vec_ready2 = 1'b0; data_bus2 = 8'h00;
        step(); step();
        total_cnt++;
        if ({inta_n, vec, vec_valid, ack_busy, spurious_cnt} !== {1'b1, 8'h00, 1'b0, 1'b0, 8'h00})
            $display("FAIL reset_state: got inta_n=%b vec=%h valid=%b busy=%b spur=%0d, want 1 00 0 0 0",
                     inta_n, vec, vec_valid, ack_busy, spurious_cnt);
        else pass_cnt++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic_ack();
        int l1, g, l2;
        int_req = 1'b1; if_flag = 1'b1; data_bus = 8'h48;
        step(); step();
        instr_boundary = 1'b1;
        total_cnt++;
        if (inta_n !== 1'b1) $display("FAIL basic_pre_strobe: inta_n=%b want 1", inta_n);
        else pass_cnt++;
        step();
        instr_boundary = 1'b0;
        total_cnt++;
        if (inta_n !== 1'b0 || ack_busy !== 1'b1)
            $display("FAIL basic_latency: inta_n=%b busy=%b want 0 1", inta_n, ack_busy);
        else pass_cnt++;
        measure_pulses(l1, g, l2);
        total_cnt++;
        if (l1 != 4 || g != 3 || l2 != 4)
            $display("FAIL basic_pulses: low=%0d gap=%0d low=%0d want 4 3 4", l1, g, l2);
        else pass_cnt++;
        total_cnt++;
        if (vec !== 8'h48 || vec_valid !== 1'b1 || ack_busy !== 1'b1)
            $display("FAIL basic_capture: vec=%h valid=%b busy=%b want 48 1 1", vec, vec_valid, ack_busy);
        else pass_cnt++;
        vec_ready = 1'b1;
        int_req = 1'b0;
        step();
        vec_ready = 1'b0;
        total_cnt++;
        if (vec_valid !== 1'b0 || ack_busy !== 1'b0 || vec !== 8'h48 || spurious_cnt !== 8'd0)
            $display("FAIL basic_transfer: valid=%b busy=%b vec=%h spur=%0d want 0 0 48 0",
                     vec_valid, ack_busy, vec, spurious_cnt);
        else pass_cnt++;
    endtask

    task automatic test_gating();
        int l1, g, l2;
        int bad = 0;
        int_req = 1'b1; if_flag = 1'b0; data_bus = 8'hA5;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            instr_boundary = 1'b1;
            step();
            instr_boundary = 1'b0;
            if (inta_n !== 1'b1 || ack_busy !== 1'b0) bad++;
            step();
        end
        total_cnt++;
        if (bad != 0) $display("FAIL gating_if0: %0d strobes started a cycle, want 0", bad);
        else pass_cnt++;
        if_flag = 1'b1;
        strobe_start();
        total_cnt++;
        if (inta_n !== 1'b0) $display("FAIL gating_start: inta_n=%b want 0", inta_n);
        else pass_cnt++;
        measure_pulses(l1, g, l2);
        total_cnt++;
        if (l1 != 4 || g != 3 || l2 != 4 || vec !== 8'hA5 || vec_valid !== 1'b1)
            $display("FAIL gating_seq: %0d/%0d/%0d vec=%h valid=%b want 4/3/4 a5 1",
                     l1, g, l2, vec, vec_valid);
        else pass_cnt++;
        vec_ready = 1'b1;
        step();
        vec_ready = 1'b0;
        int_req = 1'b0;
        step(); step();
    endtask

    task automatic test_back_to_back();
        int l1, g, l2;
        int bad = 0;
        int_req = 1'b1; data_bus = 8'h0F;
        step(); step();
        strobe_start();
        measure_pulses(l1, g, l2);
        data_bus = 8'h99;
        for (int i = 0; i < 20; i++) begin
            instr_boundary = 1'b1;
            step();
            if (vec_valid !== 1'b1 || vec !== 8'h0F || inta_n !== 1'b1) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL backpressure_hold: %0d unstable cycles, want 0", bad);
        else pass_cnt++;
        vec_ready = 1'b1;
        step();
        vec_ready = 1'b0;
        total_cnt++;
        if (vec_valid !== 1'b0 || ack_busy !== 1'b0 || inta_n !== 1'b1)
            $display("FAIL b2b_idle_gap: valid=%b busy=%b inta_n=%b want 0 0 1", vec_valid, ack_busy, inta_n);
        else pass_cnt++;
        step();
        instr_boundary = 1'b0;
        total_cnt++;
        if (inta_n !== 1'b0) $display("FAIL b2b_restart: inta_n=%b want 0", inta_n);
        else pass_cnt++;
        measure_pulses(l1, g, l2);
        total_cnt++;
        if (vec !== 8'h99 || vec_valid !== 1'b1)
            $display("FAIL b2b_second_vec: vec=%h valid=%b want 99 1", vec, vec_valid);
        else pass_cnt++;
        vec_ready = 1'b1;
        step();
        vec_ready = 1'b0;
    endtask

    task automatic test_reset_mid_inta2();
        int l1, g, l2;
        int_req = 1'b1; data_bus = 8'h55;
        step(); step();
        strobe_start();
        repeat (8) step();
        total_cnt++;
        if (inta_n !== 1'b0) $display("FAIL mid_inta2_pos: inta_n=%b want 0", inta_n);
        else pass_cnt++;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        total_cnt++;
        if (inta_n !== 1'b1 || vec_valid !== 1'b0 || ack_busy !== 1'b0 || vec !== 8'h00)
            $display("FAIL mid_reset: inta_n=%b valid=%b busy=%b vec=%h want 1 0 0 00",
                     inta_n, vec_valid, ack_busy, vec);
        else pass_cnt++;
        data_bus = 8'h3C;
        step(); step();
        strobe_start();
        measure_pulses(l1, g, l2);
        total_cnt++;
        if (l1 != 4 || g != 3 || l2 != 4 || vec !== 8'h3C || vec_valid !== 1'b1)
            $display("FAIL post_reset_seq: %0d/%0d/%0d vec=%h valid=%b want 4/3/4 3c 1",
                     l1, g, l2, vec, vec_valid);
        else pass_cnt++;
        vec_ready = 1'b1;
        int_req = 1'b0;
        step();
        vec_ready = 1'b0;
    endtask

    task automatic test_fast_params();
        int_req2 = 1'b1; data_bus2 = 8'h7E;
        step(); step();
        strobe2 = 1'b1;
        step();
        strobe2 = 1'b0;
        total_cnt++;
        if (inta_n2 !== 1'b0) $display("FAIL fast_pulse1: inta_n=%b want 0", inta_n2);
        else pass_cnt++;
        step();
        total_cnt++;
        if (inta_n2 !== 1'b1) $display("FAIL fast_gap: inta_n=%b want 1", inta_n2);
        else pass_cnt++;
        step();
        total_cnt++;
        if (inta_n2 !== 1'b0 || vec_valid2 !== 1'b0)
            $display("FAIL fast_pulse2: inta_n=%b valid=%b want 0 0", inta_n2, vec_valid2);
        else pass_cnt++;
        step();
        total_cnt++;
        if (inta_n2 !== 1'b1 || vec_valid2 !== 1'b1 || vec2 !== 8'h7E)
            $display("FAIL fast_capture: inta_n=%b valid=%b vec=%h want 1 1 7e", inta_n2, vec_valid2, vec2);
        else pass_cnt++;
        vec_ready2 = 1'b1;
        int_req2 = 1'b0;
        step();
        vec_ready2 = 1'b0;
        total_cnt++;
        if (vec_valid2 !== 1'b0 || ack_busy2 !== 1'b0)
            $display("FAIL fast_transfer: valid=%b busy=%b want 0 0", vec_valid2, ack_busy2);
        else pass_cnt++;
    endtask

`ifdef INTA_SPURIOUS_DROP_EN
    task automatic test_spurious();
        int l1, g, l2;
        logic [7:0] vec_before;
        vec_before = vec;
        data_bus = 8'hEE;
        int_req = 1'b1;
        step(); step();
        strobe_start();
        int_req = 1'b0;
        measure_pulses(l1, g, l2);
        total_cnt++;
        if (l1 != 4 || g != 3 || l2 != 4 || vec_valid !== 1'b0 || ack_busy !== 1'b0 ||
            spurious_cnt !== 8'd1 || vec !== vec_before)
            $display("FAIL spurious_one: %0d/%0d/%0d valid=%b busy=%b cnt=%0d vec=%h want 4/3/4 0 0 1 %h",
                     l1, g, l2, vec_valid, ack_busy, spurious_cnt, vec, vec_before);
        else pass_cnt++;
        for (int n = 1; n < 300; n++) begin
            int_req = 1'b1;
            step(); step();
            strobe_start();
            int_req = 1'b0;
            measure_pulses(l1, g, l2);
        end
        total_cnt++;
        if (spurious_cnt !== 8'd255) $display("FAIL spurious_sat: cnt=%0d want 255", spurious_cnt);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_ack();
        test_gating();
        test_back_to_back();
        test_reset_mid_inta2();
        test_fast_params();
`ifdef INTA_SPURIOUS_DROP_EN
        test_spurious();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
